sim_pci_irq_arbiter: RTL and testbench

Simulation model of a multi-channel PCI bridge interrupt path. It detects toggles on any of CHANNELS request lines and queues one pending interrupt per channel. It services pending interrupts one at a time in round-robin order, returning a one-cycle acknowledge pulse after a programmable delay. It also flags lost interrupts, where a channel toggles again while already pending. It is used in testbenches in place of the real PCIe bridge interrupt handshake.

---
 rtl/sim_pci_irq_arbiter.sv | 132 +++++++++++++
 tb/tb_sim_pci_irq_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_pci_irq_arbiter.sv
// Interrupt path model for a multi-channel PCI bridge.
// Level changes on IRQ_REQ queue one pending interrupt per channel. Pending
// interrupts are serviced one at a time in round-robin order. Each service
// ends with a one-cycle IRQ_ACK pulse that follows a programmable wait and is
// followed by an idle holdoff gap.
module sim_pci_irq_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int ACK_DELAY = 5,
    parameter int HOLDOFF   = 2,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] IRQ_REQ,
    input  logic [CHANNELS-1:0] IRQ_MASK,
    input  logic                OVF_CLEAR,
    output logic [CHANNELS-1:0] IRQ_ACK,
    output logic [CW-1:0]       ACK_CHANNEL,
    output logic                BUSY,
    output logic [CHANNELS-1:0] OVERFLOW
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("sim_pci_irq_arbiter: CHANNELS must be in 1..32");
    end
    if (ACK_DELAY < 1) begin : g_bad_ack_delay
        $error("sim_pci_irq_arbiter: ACK_DELAY must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLDOFF
    } state_t;

    state_t              state;
    logic [CHANNELS-1:0] prev_req;
    logic [CHANNELS-1:0] pending;
    logic [CW-1:0]       last_grant;
    logic [31:0]         counter;

    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] grant_vec;
    logic [CW-1:0]       grant_idx;
    logic [CW-1:0]       cidx;
    logic                grant_valid;

    // Round-robin pick: first eligible channel above last_grant, wrapping.
    always_comb begin
        toggle      = IRQ_REQ ^ prev_req;
        eligible    = pending & ~IRQ_MASK;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cidx        = last_grant;
        if (state == ST_IDLE) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                cidx = (cidx == CW'(CHANNELS - 1)) ? '0 : cidx + CW'(1);
                if (!grant_valid && eligible[cidx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cidx;
                end
            end
        end
        grant_vec = grant_valid ? (CHANNELS'(1) << grant_idx) : '0;
    end

    // Toggle capture, overflow flags and the service state machine.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_req    <= '0;
            pending     <= '0;
            OVERFLOW    <= '0;
            IRQ_ACK     <= '0;
            ACK_CHANNEL <= '0;
            BUSY        <= 1'b0;
            state       <= ST_IDLE;
            last_grant  <= CW'(CHANNELS - 1);
            counter     <= '0;
        end else begin
            prev_req <= IRQ_REQ;
            // A toggle landing on the grant edge re-arms pending rather than
            // being counted as lost.
            pending  <= (pending & ~grant_vec) | toggle;
            OVERFLOW <= (OVF_CLEAR ? '0 : OVERFLOW) | (toggle & pending & ~grant_vec);

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_idx;
                        counter    <= 32'(ACK_DELAY);
                        state      <= ST_WAIT;
                        BUSY       <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    counter <= counter - 32'd1;
                    if (counter == 32'd1) begin
                        state       <= ST_ACK;
                        IRQ_ACK     <= CHANNELS'(1) << last_grant;
                        ACK_CHANNEL <= last_grant;
                    end
                end
                ST_ACK: begin
                    IRQ_ACK     <= '0;
                    ACK_CHANNEL <= '0;
                    if (HOLDOFF > 0) begin
                        state   <= ST_HOLDOFF;
                        counter <= 32'(HOLDOFF);
                    end else begin
                        state   <= ST_IDLE;
                        counter <= '0;
                        BUSY    <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    counter <= counter - 32'd1;
                    if (counter == 32'd1) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_pci_irq_arbiter.sv
// Directed bench for sim_pci_irq_arbiter with default parameters.
// Cycle t means the interval after the t-th rising edge following stimulus
// time t=0. Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_sim_pci_irq_arbiter;

    logic       clk;
    logic       resetn;
    logic [3:0] IRQ_REQ;
    logic [3:0] IRQ_MASK;
    logic       OVF_CLEAR;
    logic [3:0] IRQ_ACK;
    logic [1:0] ACK_CHANNEL;
    logic       BUSY;
    logic [3:0] OVERFLOW;

    int total;
    int bad;

    int         n_ack;
    int         ack_t [16];
    int         ack_c [16];
    logic [3:0] ack_v [16];

    sim_pci_irq_arbiter #(
        .CHANNELS (4),
        .ACK_DELAY(5),
        .HOLDOFF  (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .IRQ_REQ    (IRQ_REQ),
        .IRQ_MASK   (IRQ_MASK),
        .OVF_CLEAR  (OVF_CLEAR),
        .IRQ_ACK    (IRQ_ACK),
        .ACK_CHANNEL(ACK_CHANNEL),
        .BUSY       (BUSY),
        .OVERFLOW   (OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_ack = 0;
        for (int i = 0; i < 16; i++) begin
            ack_t[i] = -1;
            ack_c[i] = -1;
            ack_v[i] = '0;
        end
    endtask

    // Log any acknowledge visible in cycle t.
    task automatic log_ack(input int t);
        if (IRQ_ACK != 4'b0000) begin
            if (n_ack < 16) begin
                ack_t[n_ack] = t;
                ack_c[n_ack] = int'(ACK_CHANNEL);
                ack_v[n_ack] = IRQ_ACK;
            end
            n_ack++;
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        IRQ_REQ   = '0;
        IRQ_MASK  = '0;
        OVF_CLEAR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
        step();
        clear_log();
    endtask

    task automatic test_reset();
        IRQ_REQ   = '0;
        IRQ_MASK  = '0;
        OVF_CLEAR = 1'b0;
        resetn    = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if ({IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW} !== 11'd0) begin
            bad++;
            $display("FAIL reset_async got ack=%b ch=%0d busy=%b ovf=%b exp all zero",
                     IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        step();
        total++;
        if ({IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW} !== 11'd0) begin
            bad++;
            $display("FAIL reset_idle got ack=%b ch=%0d busy=%b ovf=%b exp all zero",
                     IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_ack;
        logic       exp_busy;
        do_reset();
        IRQ_REQ = 4'b0001;
        for (int t = 1; t <= 22; t++) begin
            step();
            exp_ack  = (t == 7) ? 4'b0001 : 4'b0000;
            exp_busy = (t >= 2 && t <= 9);
            total++;
            if (IRQ_ACK !== exp_ack) begin
                bad++;
                $display("FAIL single_ack t=%0d got=%b exp=%b", t, IRQ_ACK, exp_ack);
            end
            total++;
            if (BUSY !== exp_busy) begin
                bad++;
                $display("FAIL single_busy t=%0d got=%b exp=%b", t, BUSY, exp_busy);
            end
            total++;
            if (ACK_CHANNEL !== 2'd0) begin
                bad++;
                $display("FAIL single_ackch t=%0d got=%0d exp=0", t, ACK_CHANNEL);
            end
        end
    endtask

    task automatic test_multi();
        int exp_c [3];
        int exp_t [3];
        exp_c = '{1, 2, 3};
        exp_t = '{7, 16, 25};
        do_reset();
        IRQ_REQ = 4'b1110;
        for (int t = 1; t <= 35; t++) begin
            step();
            log_ack(t);
        end
        total++;
        if (n_ack !== 3) begin
            bad++;
            $display("FAIL multi_count got=%0d exp=3", n_ack);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ack_c[i] !== exp_c[i] || ack_t[i] !== exp_t[i] ||
                ack_v[i] !== (4'b0001 << exp_c[i])) begin
                bad++;
                $display("FAIL multi_ack%0d got ch=%0d t=%0d vec=%b exp ch=%0d t=%0d",
                         i, ack_c[i], ack_t[i], ack_v[i], exp_c[i], exp_t[i]);
            end
        end
        total++;
        if (OVERFLOW !== 4'b0000) begin
            bad++;
            $display("FAIL multi_ovf got=%b exp=0000", OVERFLOW);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        IRQ_REQ = 4'b0001;
        for (int t = 1; t <= 30; t++) begin
            step();
            log_ack(t);
            if (t == 6) begin
                total++;
                if (OVERFLOW !== 4'b0100) begin
                    bad++;
                    $display("FAIL ovf_set got=%b exp=0100", OVERFLOW);
                end
            end
            if (t == 9) begin
                total++;
                if (OVERFLOW !== 4'b0100) begin
                    bad++;
                    $display("FAIL ovf_set_wins got=%b exp=0100", OVERFLOW);
                end
            end
            if (t == 10) begin
                total++;
                if (OVERFLOW !== 4'b0000) begin
                    bad++;
                    $display("FAIL ovf_clear got=%b exp=0000", OVERFLOW);
                end
            end
            case (t)
                3: IRQ_REQ = 4'b0101;
                5: IRQ_REQ = 4'b0001;
                8: begin
                    IRQ_REQ   = 4'b0101;
                    OVF_CLEAR = 1'b1;
                end
                9: OVF_CLEAR = 1'b1;
                10: OVF_CLEAR = 1'b0;
                default: ;
            endcase
        end
        total++;
        if (n_ack !== 2) begin
            bad++;
            $display("FAIL ovf_count got=%0d exp=2", n_ack);
        end
        total++;
        if (ack_c[0] !== 0 || ack_t[0] !== 7 || ack_c[1] !== 2 || ack_t[1] !== 16) begin
            bad++;
            $display("FAIL ovf_order got ch=%0d@%0d ch=%0d@%0d exp ch=0@7 ch=2@16",
                     ack_c[0], ack_t[0], ack_c[1], ack_t[1]);
        end
        total++;
        if (OVERFLOW !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_final got=%b exp=0000", OVERFLOW);
        end
    endtask

    task automatic test_mask();
        do_reset();
        IRQ_MASK = 4'b0010;
        IRQ_REQ  = 4'b0010;
        for (int t = 1; t <= 50; t++) begin
            step();
            log_ack(t);
        end
        total++;
        if (n_ack !== 0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL mask_hold got acks=%0d busy=%b exp acks=0 busy=0", n_ack, BUSY);
        end
        IRQ_MASK = 4'b0000;
        for (int t = 51; t <= 65; t++) begin
            step();
            log_ack(t);
        end
        total++;
        if (n_ack !== 1 || ack_c[0] !== 1 || ack_t[0] !== 56 || ack_v[0] !== 4'b0010) begin
            bad++;
            $display("FAIL mask_release got n=%0d ch=%0d t=%0d vec=%b exp n=1 ch=1 t=56 vec=0010",
                     n_ack, ack_c[0], ack_t[0], ack_v[0]);
        end
    endtask

    task automatic test_grant_toggle();
        do_reset();
        IRQ_REQ = 4'b0010;
        for (int t = 1; t <= 25; t++) begin
            step();
            log_ack(t);
            if (t == 1) IRQ_REQ = 4'b0000;
        end
        total++;
        if (n_ack !== 2 || ack_c[0] !== 1 || ack_t[0] !== 7 || ack_c[1] !== 1 || ack_t[1] !== 16) begin
            bad++;
            $display("FAIL grant_toggle got n=%0d ch=%0d@%0d ch=%0d@%0d exp n=2 ch=1@7 ch=1@16",
                     n_ack, ack_c[0], ack_t[0], ack_c[1], ack_t[1]);
        end
        total++;
        if (OVERFLOW !== 4'b0000) begin
            bad++;
            $display("FAIL grant_toggle_ovf got=%b exp=0000", OVERFLOW);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        IRQ_REQ = 4'b0001;
        for (int t = 1; t <= 4; t++) step();
        total++;
        if (BUSY !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy got=%b exp=1", BUSY);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW} !== 11'd0) begin
            bad++;
            $display("FAIL rstmid_async got ack=%b ch=%0d busy=%b ovf=%b exp all zero",
                     IRQ_ACK, ACK_CHANNEL, BUSY, OVERFLOW);
        end
        for (int t = 5; t <= 7; t++) begin
            step();
            total++;
            if (IRQ_ACK !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_noack t=%0d got=%b exp=0000", t, IRQ_ACK);
            end
        end
        resetn = 1'b1;
        clear_log();
        for (int u = 1; u <= 15; u++) begin
            step();
            log_ack(u);
        end
        total++;
        if (n_ack !== 1 || ack_c[0] !== 0 || ack_t[0] !== 7 || ack_v[0] !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_held got n=%0d ch=%0d t=%0d vec=%b exp n=1 ch=0 t=7 vec=0001",
                     n_ack, ack_c[0], ack_t[0], ack_v[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] prev_ack;
        int exp_c [3];
        int exp_t [3];
        exp_c = '{0, 3, 0};
        exp_t = '{7, 16, 25};
        prev_ack = '0;
        do_reset();
        IRQ_REQ = 4'b1001;
        for (int t = 1; t <= 35; t++) begin
            step();
            log_ack(t);
            total++;
            if (prev_ack != 4'b0000 && IRQ_ACK != 4'b0000) begin
                bad++;
                $display("FAIL rr_back_to_back t=%0d got=%b after=%b exp=0000", t, IRQ_ACK, prev_ack);
            end
            prev_ack = IRQ_ACK;
            if (t == 8) IRQ_REQ = 4'b1000;
        end
        total++;
        if (n_ack !== 3) begin
            bad++;
            $display("FAIL rr_count got=%0d exp=3", n_ack);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ack_c[i] !== exp_c[i] || ack_t[i] !== exp_t[i]) begin
                bad++;
                $display("FAIL rr_ack%0d got ch=%0d t=%0d exp ch=%0d t=%0d",
                         i, ack_c[i], ack_t[i], exp_c[i], exp_t[i]);
            end
        end
        total++;
        if (OVERFLOW !== 4'b0000) begin
            bad++;
            $display("FAIL rr_ovf got=%b exp=0000", OVERFLOW);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_log();
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_mask();
        test_grant_toggle();
        test_reset_mid();
        test_round_robin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
